// File: rtl/wb_master_bridge_pkg.sv
// Shared types for the Wishbone master bridge.
// Holds the FSM encoding, the timer width and the response flag bundle.
package wb_master_bridge_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_flags_t;

endpackage

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone B4 pipelined master driven by a local
// request/response engine, with a strobe-to-completion timeout.
// Ports:
//   sys_clk, rst_n           clock, async active-low reset
//   cmd_*                    request in (valid/ready, we, adr, dat, sel)
//   rsp_*                    response out (valid/ready, dat, err, timeout)
//   wbm_*                    Wishbone master port to the crossbar
//   busy                     FSM is not idle
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int ADR_W          = 28,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic             wbm_stb_o,
    output logic             wbm_cyc_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_stall_i,
    input  logic             wbm_err_i,
    output logic             busy
);

    localparam logic [TIMER_W-1:0] TO_LAST =
        TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q;
    rsp_flags_t         flags_q, flags_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               load_cmd;
    logic               done;
    logic               seen;
    logic               expire;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completion is only meaningful while the cycle is open; in REQ
    // it additionally needs the strobe to have been taken (stall low).
    always_comb begin
        state_d   = state_q;
        load_cmd  = 1'b0;
        done      = 1'b0;
        seen      = 1'b0;
        flags_d   = '0;
        rsp_dat_d = '0;
        expire    = (timer_q == TO_LAST);
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                seen = !wbm_stall_i && (wbm_ack_i || wbm_err_i);
                if (seen || expire) begin
                    done = 1'b1;
                end else if (!wbm_stall_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                seen = wbm_ack_i || wbm_err_i;
                done = seen || expire;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = RESP;
            if (seen) begin
                flags_d.err = wbm_err_i;
                if (!wbm_err_i && !wbm_we_o) begin
                    rsp_dat_d = wbm_dat_i;
                end
            end else begin
                flags_d.timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
        end else if (load_cmd) begin
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_we ? cmd_dat : 32'd0;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (load_cmd) begin
            timer_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= '0;
            rsp_dat_q <= '0;
        end else if (done) begin
            flags_q   <= flags_d;
            rsp_dat_q <= rsp_dat_d;
        end else if (state_q == RESP && rsp_ready) begin
            flags_q   <= '0;
            rsp_dat_q <= '0;
        end
    end

    // Cycle/strobe decode straight from state so an async reset drops
    // them without waiting for a clock edge.
    assign wbm_cyc_o   = (state_q == REQ) || (state_q == WAIT);
    assign wbm_stb_o   = (state_q == REQ);
    assign cmd_ready   = rst_n && (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_dat     = rsp_dat_q;
    assign rsp_err     = flags_q.err;
    assign rsp_timeout = flags_q.timeout;

endmodule
